// File: rtl/ghost_position_stepper_pkg.sv
// Shared playfield geometry, stepper state encoding and direction codes for the ghost movers.
package ghost_position_stepper_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int TILE_PX      = 20;
  localparam int TILE_COL_NUM = WIDTH / TILE_PX;
  localparam int TILE_ROW_NUM = HEIGHT / TILE_PX;
  localparam int WALLS_W      = TILE_ROW_NUM * TILE_COL_NUM;
  localparam int X_W          = $clog2(WIDTH);
  localparam int Y_W          = $clog2(HEIGHT);
  localparam int GHOST_HOME_X = 320;
  localparam int GHOST_HOME_Y = 240;

  localparam logic [1:0] GS_IDLE  = 2'd0;
  localparam logic [1:0] GS_CHECK = 2'd1;
  localparam logic [1:0] GS_MOVE  = 2'd2;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic logic [X_W:0] magnitude(input logic signed [X_W:0] d);
    return d[X_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/ghost_position_stepper_if.sv
// Controller <-> stepper bundle: pacing, proposed target and wall map in; position and status pulses out.
interface ghost_position_stepper_if;
  import ghost_position_stepper_pkg::*;

  logic               frame_tick;
  logic               freeze;
  logic [X_W-1:0]     next_x;
  logic [Y_W-1:0]     next_y;
  logic [WALLS_W-1:0] tilemap_walls;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               moving;
  logic               arrived;
  logic               blocked;

  modport master (
    output frame_tick, freeze, next_x, next_y, tilemap_walls,
    input  x, y, moving, arrived, blocked
  );

  modport slave (
    input  frame_tick, freeze, next_x, next_y, tilemap_walls,
    output x, y, moving, arrived, blocked
  );

endinterface

// File: rtl/ghost_position_stepper_tile_wall_lookup.sv
// Combinational pixel -> wall-bit lookup shared by the ghost and pac-man movers.
module tile_wall_lookup
  import ghost_position_stepper_pkg::*;
#(
  parameter int TILE = TILE_PX
) (
  input  logic [X_W-1:0]     i_px_x,
  input  logic [Y_W-1:0]     i_px_y,
  input  logic [WALLS_W-1:0] i_walls,
  output logic               o_wall
);

  localparam int IDX_W = $clog2(WALLS_W);

  logic [31:0] w_col;
  logic [31:0] w_row;
  logic [31:0] w_idx;

  always_comb begin
    w_col  = 32'(i_px_x) / TILE;
    w_row  = 32'(i_px_y) / TILE;
    w_idx  = w_row * TILE_COL_NUM + w_col;
    // Anything off the map reads as solid so a stray coordinate can never open a path.
    o_wall = (w_idx < WALLS_W) ? i_walls[w_idx[IDX_W-1:0]] : 1'b1;
  end

endmodule

// File: rtl/ghost_position_stepper.sv
// Validates one controller step against range/shape/wall rules, then walks the ghost there one pixel per px_tick.
module ghost_position_stepper
  import ghost_position_stepper_pkg::*;
#(
  parameter int SPEED         = 20,
  parameter int TILE          = TILE_PX,
  parameter int FRAMES_PER_PX = 1,
  parameter int HOME_X        = GHOST_HOME_X,
  parameter int HOME_Y        = GHOST_HOME_Y
) (
  input logic                     clk,
  input logic                     reset,
  ghost_position_stepper_if.slave bus
);

  localparam logic [3:0]     PACE_LAST = 4'(FRAMES_PER_PX - 1);
  localparam logic [X_W:0]   SPEED_MAG = (X_W + 1)'(SPEED);
  localparam logic [X_W-1:0] X_LIMIT   = X_W'(WIDTH);
  localparam logic [Y_W-1:0] Y_LIMIT   = Y_W'(HEIGHT);

  logic [1:0]     r_state;
  logic [3:0]     r_pace;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] r_tx;
  logic [Y_W-1:0] r_ty;
  dir_e           r_dir;
  logic           r_arrived;
  logic           r_blocked;

  logic                  w_run;
  logic                  w_px_tick;
  logic                  w_wall;
  logic                  w_valid;
  logic signed [X_W:0]   w_dx;
  logic signed [Y_W:0]   w_dy;
  logic [X_W:0]          w_mag;
  dir_e                  w_dir;
  logic [X_W-1:0]        w_step_x;
  logic [Y_W-1:0]        w_step_y;
  logic                  w_hit;

  assign w_run     = ~bus.freeze;
  assign w_px_tick = bus.frame_tick & w_run & (r_pace == PACE_LAST);

  tile_wall_lookup #(.TILE(TILE)) u_wall_lookup (
    .i_px_x  (r_tx),
    .i_px_y  (r_ty),
    .i_walls (bus.tilemap_walls),
    .o_wall  (w_wall)
  );

  // Target validation; differences are one bit wider than the coordinate so wrapped targets stay out of range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_mag = '0;
    w_dir = DIR_UP;
    w_dx  = $signed({1'b0, r_tx}) - $signed({1'b0, r_x});
    w_dy  = $signed({1'b0, r_ty}) - $signed({1'b0, r_y});
    if (|w_dx) begin
      w_mag = magnitude(w_dx);
      w_dir = w_dx[X_W] ? DIR_LEFT : DIR_RIGHT;
    end else begin
      w_mag = magnitude({{(X_W - Y_W){w_dy[Y_W]}}, w_dy});
      w_dir = w_dy[Y_W] ? DIR_UP : DIR_DOWN;
    end
    w_valid = (r_tx < X_LIMIT) && (r_ty < Y_LIMIT) && ((|w_dx) ^ (|w_dy))
              && (w_mag == SPEED_MAG) && !w_wall;
  end

  always_comb begin
    w_step_x = r_x;
    w_step_y = r_y;
    case (r_dir)
      DIR_LEFT:  w_step_x = r_x - X_W'(1);
      DIR_RIGHT: w_step_x = r_x + X_W'(1);
      DIR_UP:    w_step_y = r_y - Y_W'(1);
      DIR_DOWN:  w_step_y = r_y + Y_W'(1);
      default:   w_step_x = r_x;
    endcase
    w_hit = (w_step_x == r_tx) && (w_step_y == r_ty);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= GS_IDLE;
      r_pace    <= '0;
      r_x       <= X_W'(HOME_X);
      r_y       <= Y_W'(HOME_Y);
      r_tx      <= X_W'(HOME_X);
      r_ty      <= Y_W'(HOME_Y);
      r_dir     <= DIR_UP;
      r_arrived <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_arrived <= 1'b0;
      r_blocked <= 1'b0;
      if (bus.frame_tick && w_run)
        r_pace <= (r_pace == PACE_LAST) ? '0 : r_pace + 4'd1;
      // Freeze holds the whole machine; a px_tick seen in CHECK is spent on pacing only.
      if (w_run) begin
        case (r_state)
          GS_IDLE: begin
            if (w_px_tick) begin
              r_tx    <= bus.next_x;
              r_ty    <= bus.next_y;
              r_state <= GS_CHECK;
            end
          end
          GS_CHECK: begin
            if (w_valid) begin
              r_dir   <= w_dir;
              r_state <= GS_MOVE;
            end else begin
              r_blocked <= 1'b1;
              r_state   <= GS_IDLE;
            end
          end
          GS_MOVE: begin
            if (w_px_tick) begin
              r_x <= w_step_x;
              r_y <= w_step_y;
              if (w_hit) begin
                r_arrived <= 1'b1;
                r_state   <= GS_IDLE;
              end
            end
          end
          default: r_state <= GS_IDLE;
        endcase
      end
    end
  end

  assign bus.x       = r_x;
  assign bus.y       = r_y;
  assign bus.moving  = (r_state == GS_MOVE);
  assign bus.arrived = r_arrived & w_run;
  assign bus.blocked = r_blocked & w_run;

endmodule
